// File: rtl/wb_regfile.sv
// 32x32 write-back register file: async active-low reset, combinational reads, r0 hardwired to 0.
// Define WB_REGFILE_BYPASS_EN to forward the pending write-back value to a matching read port.
module wb_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [31:0] ReadMem_i,
    input  logic [31:0] ALUresult_i,
    input  logic [4:0]  RegRD_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    output logic [31:0] RSdata_o,
    output logic [31:0] RTdata_o,
    output logic [31:0] WBdata_o,
    output logic        WBen_o
);

    logic [31:0] regs_q [32];
    logic [31:0] wb_data;
    logic        wb_en;

    assign wb_data  = WB_i[0] ? ReadMem_i : ALUresult_i;
    assign wb_en    = WB_i[1] & (RegRD_i != 5'd0);
    assign WBdata_o = wb_data;
    assign WBen_o   = wb_en;

    // Entry 0 is only ever cleared; wb_en already excludes index 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wb_en) begin
            regs_q[RegRD_i] <= wb_data;
        end
    end

    always_comb begin
        RSdata_o = (RSaddr_i == 5'd0) ? 32'd0 : regs_q[RSaddr_i];
        RTdata_o = (RTaddr_i == 5'd0) ? 32'd0 : regs_q[RTaddr_i];
`ifdef WB_REGFILE_BYPASS_EN
        // Bypass is held off during reset so reads stay zero while rst_i is low.
        if (rst_i && wb_en && (RSaddr_i == RegRD_i)) begin
            RSdata_o = wb_data;
        end
        if (rst_i && wb_en && (RTaddr_i == RegRD_i)) begin
            RTdata_o = wb_data;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic against an array model.
// Expected read values follow the WB_REGFILE_BYPASS_EN setting of the build.
module tb_wb_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i;
    logic [31:0] ReadMem_i;
    logic [31:0] ALUresult_i;
    logic [4:0]  RegRD_i;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic [31:0] RSdata_o;
    logic [31:0] RTdata_o;
    logic [31:0] WBdata_o;
    logic        WBen_o;

    wb_regfile dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .WB_i        (WB_i),
        .ReadMem_i   (ReadMem_i),
        .ALUresult_i (ALUresult_i),
        .RegRD_i     (RegRD_i),
        .RSaddr_i    (RSaddr_i),
        .RTaddr_i    (RTaddr_i),
        .RSdata_o    (RSdata_o),
        .RTdata_o    (RTdata_o),
        .WBdata_o    (WBdata_o),
        .WBen_o      (WBen_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [32];
    logic [31:0] cur_data;
    logic        cur_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
        if (rst_i && cur_en && idx == RegRD_i) return cur_data;
`endif
        return model[idx];
    endfunction

    task automatic drive(input logic [1:0] wb, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        WB_i        = wb;
        ReadMem_i   = mem;
        ALUresult_i = alu;
        RegRD_i     = rd;
        RSaddr_i    = rs;
        RTaddr_i    = rt;
        cur_en      = wb[1] && (rd != 5'd0);
        cur_data    = wb[0] ? mem : alu;
    endtask

    task automatic check_reads(input string tag);
        check({tag, ".rs"}, RSdata_o, exp_read(RSaddr_i));
        check({tag, ".rt"}, RTdata_o, exp_read(RTaddr_i));
    endtask

    // Entered and left at posedge+1: check pre-edge outputs, clock, check post-edge reads.
    task automatic step(input string tag);
        #1;
        check({tag, ".wbdata"}, WBdata_o, cur_data);
        check({tag, ".wben"}, {31'd0, WBen_o}, {31'd0, cur_en});
        check_reads({tag, ".pre"});
        @(posedge clk_i);
        if (rst_i && cur_en) model[RegRD_i] = cur_data;
        #1;
        check_reads({tag, ".post"});
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            RSaddr_i = 5'(i);
            RTaddr_i = 5'(31 - i);
            #1;
            check({tag, ".rs"}, RSdata_o, 32'd0);
            check({tag, ".rt"}, RTdata_o, 32'd0);
        end
    endtask

    task automatic reset_pulse(input string tag);
        drive(2'b00, 32'd0, 32'd0, 5'd0, RSaddr_i, RTaddr_i);
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #1;
        sweep_zero(tag);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst_i = 1'b0;
        drive(2'b10, 32'd0, 32'h1111_1111, 5'd4, 5'd4, 5'd4);
        // Write attempted across edges while reset is held: must be suppressed.
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("rst.wben_comb", {31'd0, WBen_o}, 32'd1);
        check("rst.wbdata_comb", WBdata_o, 32'h1111_1111);
        check("rst.r4", RSdata_o, 32'd0);
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        sweep_zero("rst.all");
        #2 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd4, 5'd31);
        step("after_rst");

        drive(2'b10, 32'h0, 32'hDEAD_BEEF, 5'd3, 5'd3, 5'd0);
        step("alu_r3");
        check("alu_r3.val", RSdata_o, 32'hDEAD_BEEF);
        drive(2'b11, 32'hCAFE_F00D, 32'h0, 5'd3, 5'd3, 5'd3);
        step("mem_r3");
        check("mem_r3.val", RSdata_o, 32'hCAFE_F00D);

        drive(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        step("r0_write");
        check("r0_write.wben", {31'd0, WBen_o}, 32'd0);
        check("r0_write.val", RSdata_o, 32'd0);

        drive(2'b10, 32'h0, 32'h0000_0777, 5'd7, 5'd7, 5'd7);
        step("r7_init");
        drive(2'b00, 32'h0, 32'h0000_0055, 5'd7, 5'd7, 5'd7);
        step("no_we");
        check("no_we.r7", RSdata_o, 32'h0000_0777);
        check("no_we.wbdata", WBdata_o, 32'h0000_0055);

        drive(2'b10, 32'h0, 32'h0BAD_BEEF, 5'd9, 5'd0, 5'd0);
        step("r9_old");
        drive(2'b10, 32'h0, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("same_cyc.rs", RSdata_o, 32'hA5A5_A5A5);
        check("same_cyc.rt", RTdata_o, 32'hA5A5_A5A5);
`else
        check("same_cyc.rs", RSdata_o, 32'h0BAD_BEEF);
        check("same_cyc.rt", RTdata_o, 32'h0BAD_BEEF);
`endif
        #1 @(posedge clk_i);
        model[9] = 32'hA5A5_A5A5;
        #1;
        check("same_cyc.post_rs", RSdata_o, 32'hA5A5_A5A5);
        check("same_cyc.post_rt", RTdata_o, 32'hA5A5_A5A5);

        drive(2'b10, 32'h0, 32'd1, 5'd1, 5'd1, 5'd2);
        step("b2b1");
        drive(2'b10, 32'h0, 32'd2, 5'd2, 5'd1, 5'd2);
        step("b2b2");
        drive(2'b10, 32'h0, 32'd3, 5'd1, 5'd1, 5'd2);
        step("b2b3");
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
        #1;
        check("b2b.r1", RSdata_o, 32'd3);
        check("b2b.r2", RTdata_o, 32'd2);
        #1 @(posedge clk_i);
        #1;

        drive(2'b10, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
        step("r5_set");
        check("r5_set.val", RSdata_o, 32'h0000_1234);
        reset_pulse("midrun_rst");

        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            logic [4:0] rs;
            logic [4:0] rt;
            rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rs = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7));
            rt = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse("rand_rst");
            end else begin
                drive(2'($urandom), $urandom, $urandom, rd, rs, rt);
                step("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port WB_i, input, 2 bits: write-back control from the MEM/WB register; bit1 = RegWrite, bit0 = MemtoReg.
REQ-004 SHALL have port ReadMem_i, input, 32 bits: load data from MEM/WB.
REQ-005 SHALL have port ALUresult_i, input, 32 bits: ALU result from MEM/WB.
REQ-006 SHALL have port RegRD_i, input, 5 bits: destination register index from MEM/WB.
REQ-007 SHALL have port RSaddr_i, input, 5 bits: read port A index, from ID.
REQ-008 SHALL have port RTaddr_i, input, 5 bits: read port B index, from ID.
REQ-009 SHALL have port RSdata_o, output, 32 bits: read port A data.
REQ-010 SHALL have port RTdata_o, output, 32 bits: read port B data.
REQ-011 SHALL have port WBdata_o, output, 32 bits: selected write-back value, feeding the EX forwarding mux.
REQ-012 SHALL have port WBen_o, output, 1 bit: qualified write enable, equal to WB_i[1] AND (RegRD_i != 0).

Function
REQ-013 SHALL drive WBdata_o combinationally: ReadMem_i when WB_i[0]=1, else ALUresult_i.
REQ-014 SHALL hold 32 registers of 32 bits each, indexed 0..31.
REQ-015 SHALL write WBdata_o into register RegRD_i on the rising clk_i edge when WBen_o=1; no other register changes on that edge.
REQ-016 SHALL keep register 0 reading as 0 at all times; writes with RegRD_i=0 are discarded and WBen_o=0.
REQ-017 SHALL read combinationally: RSdata_o = reg[RSaddr_i] and RTdata_o = reg[RTaddr_i], with zero added latency.
REQ-018 SHALL resolve RSaddr_i = RTaddr_i = RegRD_i by returning the identical value on both ports.
REQ-019 SHALL perform no write when WB_i[1]=0, regardless of the other inputs; X on ReadMem_i or ALUresult_i is then harmless.
REQ-020 SHALL make a value written on edge N visible on the read ports from edge N onward, combinationally after that edge.

Reset
REQ-021 SHALL, while rst_i=0, asynchronously clear all 32 registers to 0x00000000, independent of clk_i.
REQ-022 SHALL make RSdata_o and RTdata_o read 0 for every index during reset and in the cycle after reset.
REQ-023 SHALL suppress any write whose edge coincides with rst_i=0; reset wins.
REQ-024 SHALL leave WBdata_o and WBen_o purely combinational and unaffected by reset.

Configuration
REQ-025 SHALL use the macro WB_REGFILE_BYPASS_EN to select same-cycle write-to-read bypass.
REQ-026 SHALL, with WB_REGFILE_BYPASS_EN defined, return WBdata_o on a read port whose index equals RegRD_i in a cycle where WBen_o=1, before the write edge.
REQ-027 SHALL, without WB_REGFILE_BYPASS_EN, return the stored (pre-write) value in that cycle and the new value only after the edge.
REQ-028 SHALL never bypass for index 0 in either build.

Verification
REQ-029 SHALL cover: reset low mid-run after writing r5=0x1234 -> r5 and every other index read 0 immediately, before any clock edge.
REQ-030 SHALL cover: WB_i=2'b10, ALUresult_i=0xDEADBEEF, RegRD_i=3, then edge -> RSaddr_i=3 reads 0xDEADBEEF; WB_i=2'b11, ReadMem_i=0xCAFEF00D, RegRD_i=3, then edge -> reads 0xCAFEF00D.
REQ-031 SHALL cover: WB_i=2'b10, RegRD_i=0, ALUresult_i=0xFFFFFFFF, then edge -> WBen_o=0 and r0 reads 0.
REQ-032 SHALL cover: WB_i=2'b00, RegRD_i=7, ALUresult_i=0x55 -> r7 is unchanged after the edge and WBdata_o=0x55.
REQ-033 SHALL cover: write r9=0xA5A5A5A5 while RSaddr_i=RTaddr_i=9 in the same cycle -> both ports read 0xA5A5A5A5 before the edge with WB_REGFILE_BYPASS_EN defined, and the old value before the edge without it; both builds read 0xA5A5A5A5 after the edge.
REQ-034 SHALL cover: back-to-back writes r1=1, r2=2, r1=3 on consecutive edges -> r1 reads 3 and r2 reads 2.
